extbus_arbiter: RTL and testbench

- Shares the single external bus between two masters: requester 0 (core memory-management path) and requester 1 (DMA/debug port).
- Owns the external bus pins: enable, write-enable, size, address, data drive, and the data-pad enables.
- Round-robin arbitration, with an urgent override for requester 1.
- One transfer in flight at a time; completion is either a `bus_rdy` handshake or a timeout.

---
 rtl/extbus_arbiter.sv | 132 +++++++++++++
 tb/tb_extbus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extbus_arbiter.sv
// rtl/extbus_arbiter.sv - two-master round-robin arbiter for the external bus
module extbus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      r0_req,
  input  logic                      r1_req,
  input  logic                      r0_we,
  input  logic                      r1_we,
  input  logic [1:0]                r0_size,
  input  logic [1:0]                r1_size,
  input  logic [EXT_ADDR_WIDTH-1:0] r0_addr,
  input  logic [EXT_ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]     r0_wdata,
  input  logic [DATA_WIDTH-1:0]     r1_wdata,
  input  logic                      r1_urgent,
  input  logic                      bus_rdy,
  input  logic [DATA_WIDTH-1:0]     data_bus_recv,
  output logic                      r0_done,
  output logic                      r1_done,
  output logic                      r0_err,
  output logic                      r1_err,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      bus_en,
  output logic                      bus_we,
  output logic [1:0]                bus_size,
  output logic [EXT_ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0]     data_bus_drv,
  output logic                      data_bus_o_en,
  output logic                      data_bus_i_en,
  output logic                      busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      owner;
  logic                      ptr;
  logic                      we_q;
  logic [1:0]                size_q;
  logic [EXT_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [CW-1:0]             cnt;
  logic                      err_q;
  logic                      grant1;
  logic                      terminal;

  // Urgent requester 1 overrides the pointer; a lone requester always wins.
  assign grant1   = r1_req && (r1_urgent || !r0_req || ptr);
  assign terminal = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (r0_req || r1_req) state_nxt = XFER;
      XFER:    if (bus_rdy || terminal) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner   <= 1'b0;
      ptr     <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner   <= grant1;
            we_q    <= grant1 ? r1_we    : r0_we;
            size_q  <= grant1 ? r1_size  : r0_size;
            addr_q  <= grant1 ? r1_addr  : r0_addr;
            wdata_q <= grant1 ? r1_wdata : r0_wdata;
            cnt     <= '0;
          end
        end
        XFER: begin
          // A ready at the terminal count still completes successfully.
          if (bus_rdy) begin
            rdata_q <= we_q ? '0 : data_bus_recv;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (terminal) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        DONE:    ptr <= ~owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_en        = (state == XFER);
    bus_we        = we_q;
    bus_size      = size_q;
    bus_addr      = addr_q;
    data_bus_o_en = (state == XFER) && we_q;
    data_bus_i_en = (state == XFER) && !we_q;
    data_bus_drv  = ((state == XFER) && we_q) ? wdata_q : '0;
    r0_done       = (state == DONE) && !owner;
    r1_done       = (state == DONE) && owner;
    r0_err        = (state == DONE) && !owner && err_q;
    r1_err        = (state == DONE) && owner && err_q;
    rdata         = rdata_q;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_extbus_arbiter.sv
// tb/tb_extbus_arbiter.sv - self-checking bench for extbus_arbiter
module tb_extbus_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          r0_req, r1_req, r0_we, r1_we;
  logic [1:0]    r0_size, r1_size;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r1_urgent, bus_rdy;
  logic [DW-1:0] data_bus_recv;
  logic          r0_done, r1_done, r0_err, r1_err;
  logic [DW-1:0] rdata;
  logic          bus_en, bus_we;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] data_bus_drv;
  logic          data_bus_o_en, data_bus_i_en, busy;

  extbus_arbiter #(.DATA_WIDTH(DW), .EXT_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_size(r0_size), .r1_size(r1_size), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata), .r1_urgent(r1_urgent),
    .bus_rdy(bus_rdy), .data_bus_recv(data_bus_recv),
    .r0_done(r0_done), .r1_done(r1_done), .r0_err(r0_err), .r1_err(r1_err),
    .rdata(rdata), .bus_en(bus_en), .bus_we(bus_we), .bus_size(bus_size),
    .bus_addr(bus_addr), .data_bus_drv(data_bus_drv),
    .data_bus_o_en(data_bus_o_en), .data_bus_i_en(data_bus_i_en), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the bus, how long it has waited,
  // and whether a completion is being reported this cycle.
  int            m_own;
  bit            m_done;
  int            m_done_own;
  bit            m_err;
  int            m_wait;
  bit            m_pref1;
  bit            m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic void model_step();
    int w;
    w = -1;
    if (!reset_n) begin
      m_own = -1; m_done = 0; m_done_own = 0; m_err = 0; m_wait = 0; m_pref1 = 0;
      m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (m_done) begin
      m_done  = 0;
      m_pref1 = (m_done_own == 0);
    end else if (m_own >= 0) begin
      if (bus_rdy || m_wait == TO - 1) begin
        m_err      = !bus_rdy;
        m_rdata    = (bus_rdy && !m_we) ? data_bus_recv : '0;
        m_done     = 1;
        m_done_own = m_own;
        m_own      = -1;
      end else begin
        m_wait++;
      end
    end else begin
      if (r1_req && r1_urgent)     w = 1;
      else if (r0_req && r1_req)   w = m_pref1 ? 1 : 0;
      else if (r0_req)             w = 0;
      else if (r1_req)             w = 1;
      if (w >= 0) begin
        m_own   = w;
        m_wait  = 0;
        m_we    = (w == 1) ? r1_we    : r0_we;
        m_size  = (w == 1) ? r1_size  : r0_size;
        m_addr  = (w == 1) ? r1_addr  : r0_addr;
        m_wdata = (w == 1) ? r1_wdata : r0_wdata;
      end
    end
  endfunction

  task automatic compare_model();
    bit xf;
    xf = (m_own >= 0);
    check("m_bus_en", bus_en, xf);
    check("m_bus_we", bus_we, m_we);
    check("m_bus_size", bus_size, m_size);
    check("m_bus_addr", bus_addr, m_addr);
    check("m_o_en", data_bus_o_en, xf && m_we);
    check("m_i_en", data_bus_i_en, xf && !m_we);
    check("m_drv", data_bus_drv, (xf && m_we) ? m_wdata : '0);
    check("m_r0_done", r0_done, m_done && m_done_own == 0);
    check("m_r1_done", r1_done, m_done && m_done_own == 1);
    check("m_r0_err", r0_err, m_done && m_done_own == 0 && m_err);
    check("m_r1_err", r1_err, m_done && m_done_own == 1 && m_err);
    check("m_rdata", rdata, m_rdata);
    check("m_busy", busy, xf || m_done);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit            req;
    bit            rdy;
    logic [DW-1:0] recv;
    bit            en;
    bit            ien;
    bit            done;
    bit            err;
    logic [DW-1:0] rd;
    bit            bsy;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t t1[6];
  int   order[$];
  int   en_cnt;
  bit   seen;

  initial begin
    t1[0] = '{1, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1, 16'h1234};
    t1[1] = '{1, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1, 16'h1234};
    t1[2] = '{1, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1, 16'h1234};
    t1[3] = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'hDEADBEEF, 1, 16'h1234};
    t1[4] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0, 16'h1234};
    t1[5] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0, 16'h1234};

    reset_n = 0; r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
    r0_size = 0; r1_size = 0; r0_addr = 0; r1_addr = 0;
    r0_wdata = 0; r1_wdata = 0; r1_urgent = 0; bus_rdy = 0; data_bus_recv = 0;
    cycle();
    cycle();
    check("rst_bus_en", bus_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_drv", data_bus_drv, 0);
    reset_n = 1;

    // single r0 read, ready on third XFER cycle
    r0_addr = 16'h1234; r0_size = 2'd2; r0_we = 0;
    for (int i = 0; i < 6; i++) begin
      r0_req = t1[i].req; bus_rdy = t1[i].rdy; data_bus_recv = t1[i].recv;
      cycle();
      check($sformatf("t1_en[%0d]", i), bus_en, t1[i].en);
      check($sformatf("t1_ien[%0d]", i), data_bus_i_en, t1[i].ien);
      check($sformatf("t1_done[%0d]", i), r0_done, t1[i].done);
      check($sformatf("t1_err[%0d]", i), r0_err, t1[i].err);
      check($sformatf("t1_rdata[%0d]", i), rdata, t1[i].rd);
      check($sformatf("t1_busy[%0d]", i), busy, t1[i].bsy);
      check($sformatf("t1_addr[%0d]", i), bus_addr, t1[i].addr);
      check($sformatf("t1_size[%0d]", i), bus_size, 2'd2);
    end

    // round-robin with both requesting continuously
    reset_n = 0; cycle(); reset_n = 1;
    r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0; bus_rdy = 1; data_bus_recv = 32'h0BADF00D;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (r0_done) order.push_back(0);
      if (r1_done) order.push_back(1);
      if (r0_done || r1_done) check("t2_gap_en", bus_en, 0);
    end
    check("t2_ngrants", order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("t2_order[%0d]", i), order[i], i % 2);

    // urgent r1 write overrides pointer that favours r0
    r1_urgent = 1; r1_we = 1; r1_wdata = 32'hA5A5A5A5; bus_rdy = 0;
    cycle();
    check("t3_o_en", data_bus_o_en, 1);
    check("t3_i_en", data_bus_i_en, 0);
    check("t3_drv", data_bus_drv, 32'hA5A5A5A5);
    bus_rdy = 1;
    cycle();
    check("t3_r1_done", r1_done, 1);
    check("t3_r0_done", r0_done, 0);
    r1_req = 0; r1_urgent = 0; bus_rdy = 0; data_bus_recv = 32'h12345678;
    cycle();
    check("t3_idle_en", bus_en, 0);
    cycle();
    check("t3_r0_en", bus_en, 1);
    check("t3_r0_ien", data_bus_i_en, 1);
    bus_rdy = 1;
    cycle();
    check("t3_r0_done2", r0_done, 1);
    check("t3_rdata", rdata, 32'h12345678);
    r0_req = 0; bus_rdy = 0;
    cycle();

    // timeout
    r0_req = 1; r0_we = 0; bus_rdy = 0; en_cnt = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle();
      if (bus_en) en_cnt++;
      if (r0_done) begin
        seen = 1;
        check("t4_err", r0_err, 1);
        check("t4_rdata", rdata, 0);
      end
    end
    check("t4_seen_done", seen, 1);
    check("t4_en_cycles", en_cnt, TO);
    r0_req = 0;
    cycle();

    // reset during an r1 write
    r1_req = 1; r1_we = 1; r1_wdata = 32'hCAFEF00D; bus_rdy = 0;
    cycle();
    cycle();
    reset_n = 0;
    cycle();
    check("t5_en", bus_en, 0);
    check("t5_o_en", data_bus_o_en, 0);
    check("t5_busy", busy, 0);
    check("t5_done", r1_done, 0);
    reset_n = 1;
    cycle();
    check("t5_regrant_en", bus_en, 1);
    check("t5_regrant_drv", data_bus_drv, 32'hCAFEF00D);
    cycle();
    bus_rdy = 1;
    cycle();
    check("t5_done2", r1_done, 1);
    check("t5_err2", r1_err, 0);
    r1_req = 0; bus_rdy = 0;
    cycle();

    // address change mid-transfer
    r0_addr = 16'h0010; r0_req = 1; r0_we = 0;
    cycle();
    check("t6_addr0", bus_addr, 16'h0010);
    r0_addr = 16'h0020;
    cycle();
    check("t6_addr1", bus_addr, 16'h0010);
    cycle();
    check("t6_addr2", bus_addr, 16'h0010);
    bus_rdy = 1;
    cycle();
    check("t6_done", r0_done, 1);
    check("t6_addr_done", bus_addr, 16'h0010);
    r0_req = 0; bus_rdy = 0;
    cycle();

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      r0_req        = $urandom_range(0, 1);
      r1_req        = $urandom_range(0, 1);
      r0_we         = $urandom_range(0, 1);
      r1_we         = $urandom_range(0, 1);
      r0_size       = 2'($urandom);
      r1_size       = 2'($urandom);
      r0_addr       = AW'($urandom);
      r1_addr       = AW'($urandom);
      r0_wdata      = $urandom;
      r1_wdata      = $urandom;
      r1_urgent     = ($urandom_range(0, 3) == 0);
      bus_rdy       = ($urandom_range(0, 3) == 0);
      data_bus_recv = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
